// File: rtl/trng_pkg.sv
// Shared types and default constants for the TRNG post-processing block.
package trng_pkg;

  // Width of the assembled output word.
  localparam int unsigned BYTE_W = 8;

  // Default health-test and synchroniser settings.
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned RCT_CUTOFF_DEF  = 32;
  localparam int unsigned APT_WINDOW_DEF  = 512;
  localparam int unsigned APT_CUTOFF_DEF  = 400;

  // Von Neumann pair state: waiting for the first or the second bit of a pair.
  typedef enum logic {
    EMPTY      = 1'b0,
    HAVE_FIRST = 1'b1
  } pair_state_e;

endpackage

// File: rtl/trng_sync.sv
// Single-bit multi-flop synchroniser with asynchronous reset to 0.
module trng_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses <= so every flop samples its pre-edge value.
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processor: input synchronisation, sample strobe, repetition-count
// health test, von Neumann de-biasing, byte packing and a valid/ready output.
// Optional adaptive proportion test enabled by defining TRNG_APT_EN.
module trng_postproc
  import trng_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned RCT_CUTOFF  = RCT_CUTOFF_DEF
`ifdef TRNG_APT_EN
  ,
  parameter int unsigned APT_WINDOW  = APT_WINDOW_DEF,
  parameter int unsigned APT_CUTOFF  = APT_CUTOFF_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              raw_bit,
  input  logic              sample_clk,
  input  logic              clear_err,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              health_fail,
  output logic              overrun
);

  localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);
  localparam int unsigned CNT_W = $clog2(BYTE_W);

  logic raw_sync, sclk_sync;

  trng_sync #(.STAGES(SYNC_STAGES)) u_sync_raw (
    .clk(clk), .rst_n(rst_n), .d_i(raw_bit), .q_o(raw_sync)
  );
  trng_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sample_clk), .q_o(sclk_sync)
  );

  logic sclk_prev_q, samp_stb_q, samp_bit_q, stb;
  logic health_fail_q, overrun_q, data_valid_q;
  logic [BYTE_W-1:0] data_out_q;

  // Rising-edge detect on the synced sample clock; capture the raw bit with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      samp_stb_q  <= 1'b0;
      samp_bit_q  <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_sync;
      samp_stb_q  <= enable & sclk_sync & ~sclk_prev_q;
      if (sclk_sync && !sclk_prev_q) samp_bit_q <= raw_sync;
    end
  end

  // A strobe already in flight when enable drops is ignored.
  assign stb = samp_stb_q & enable;

  // ---------------- Repetition count test ----------------
  logic [RCT_W-1:0] rct_cnt_q, rct_cnt_d;
  logic             prev_bit_q, rct_trip;

  // Next RCT count; a zero count marks the first sample after reset/enable/clear.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    rct_cnt_d = rct_cnt_q;
    rct_trip  = 1'b0;
    if (stb) begin
      if (rct_cnt_q == '0 || samp_bit_q != prev_bit_q) rct_cnt_d = RCT_W'(1);
      else if (rct_cnt_q != RCT_W'(RCT_CUTOFF))        rct_cnt_d = rct_cnt_q + 1'b1;
      rct_trip = (rct_cnt_d == RCT_W'(RCT_CUTOFF));
    end
    if (!enable || clear_err) rct_cnt_d = '0;
  end

  // RCT counter and previous-sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt_q  <= '0;
      prev_bit_q <= 1'b0;
    end else begin
      rct_cnt_q <= rct_cnt_d;
      if (stb) prev_bit_q <= samp_bit_q;
    end
  end

  // ---------------- Adaptive proportion test (optional) ----------------
  logic apt_trip;
`ifdef TRNG_APT_EN
  localparam int unsigned APT_W = $clog2(APT_WINDOW + 1);
  logic [APT_W-1:0] apt_n_q, apt_n_d, apt_m_q, apt_m_d;
  logic             apt_ref_q, apt_ref_d;

  // Window bookkeeping: the first sample sets the reference, the rest are matched.
  always_comb begin
    apt_n_d   = apt_n_q;
    apt_m_d   = apt_m_q;
    apt_ref_d = apt_ref_q;
    apt_trip  = 1'b0;
    if (stb) begin
      if (apt_n_q == '0) begin
        apt_ref_d = samp_bit_q;
        apt_n_d   = APT_W'(1);
        apt_m_d   = APT_W'(1);
      end else begin
        apt_n_d = apt_n_q + 1'b1;
        apt_m_d = apt_m_q + APT_W'(samp_bit_q == apt_ref_q);
      end
      apt_trip = (apt_m_d >= APT_W'(APT_CUTOFF));
      if (apt_n_d == APT_W'(APT_WINDOW)) apt_n_d = '0;
    end
    if (!enable || clear_err) begin
      apt_n_d = '0;
      apt_m_d = '0;
    end
  end

  // APT window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apt_n_q   <= '0;
      apt_m_q   <= '0;
      apt_ref_q <= 1'b0;
    end else begin
      apt_n_q   <= apt_n_d;
      apt_m_q   <= apt_m_d;
      apt_ref_q <= apt_ref_d;
    end
  end
`else
  assign apt_trip = 1'b0;
`endif

  // ---------------- Von Neumann pair FSM ----------------
  pair_state_e state_q, state_d;
  logic        first_q, first_d, emit, emit_bit;

  // Pair next-state: unequal pairs emit their first bit, equal pairs emit nothing.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    emit     = 1'b0;
    emit_bit = first_q;
    case (state_q)
      EMPTY: if (stb) begin
        first_d = samp_bit_q;
        state_d = HAVE_FIRST;
      end
      HAVE_FIRST: if (stb) begin
        emit    = (first_q != samp_bit_q);
        state_d = EMPTY;
      end
    endcase
    if (!enable) state_d = EMPTY;
  end

  // Pair state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // ---------------- Byte assembly ----------------
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [BYTE_W-1:0] shreg_q, byte_full;
  logic              accept, byte_done, load, drop;

  assign accept    = emit & ~health_fail_q;
  assign byte_done = accept & (bit_cnt_q == CNT_W'(BYTE_W - 1));
  assign load      = byte_done & (~data_valid_q | data_ready);
  assign drop      = byte_done & data_valid_q & ~data_ready;

  // Current partial byte with the emitted bit dropped into position bit_cnt.
  always_comb begin
    byte_full            = shreg_q;
    byte_full[bit_cnt_q] = emit_bit;
  end

  // Partial-byte register and bit position; disabling discards the partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (!enable) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (accept) begin
      shreg_q   <= byte_full;
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  // Output holding register with valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else if (load) begin
      data_out_q   <= byte_full;
      data_valid_q <= 1'b1;
    end else if (data_valid_q && data_ready) begin
      data_valid_q <= 1'b0;
    end
  end

  // Sticky flags; clear_err wins over a simultaneous set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health_fail_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else if (clear_err) begin
      health_fail_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (rct_trip || apt_trip) health_fail_q <= 1'b1;
      if (drop)                 overrun_q     <= 1'b1;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign health_fail = health_fail_q;
  assign overrun     = overrun_q;

endmodule
